// File: rtl/aes_gcm_arbiter.sv
// Shares one aes_gcm engine between NUM_CH channels; each grant spans a full key/IV/data/tag session.
// Define GCM_ARB_FIXED_PRIO_EN for fixed-priority arbitration (lowest index wins) instead of round-robin.
module aes_gcm_arbiter #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned KEY_SIZE = 128,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            req_i,
    input  logic [NUM_CH-1:0]            mode_i,
    input  logic [NUM_CH*KEY_SIZE-1:0]   key_i,
    input  logic [NUM_CH*96-1:0]         iv_i,
    input  logic [NUM_CH*128-1:0]        din_i,
    input  logic [NUM_CH-1:0]            din_valid_i,
    input  logic [NUM_CH-1:0]            din_last_i,
    output logic [NUM_CH-1:0]            din_ready_o,
    output logic [127:0]                 dout_o,
    output logic [NUM_CH-1:0]            dout_valid_o,
    output logic [127:0]                 tag_o,
    output logic [NUM_CH-1:0]            tag_valid_o,
    output logic [NUM_CH-1:0]            grant_o,
    output logic                         busy_o,
    output logic [CNT_W-1:0]             sess_cnt_o,
    output logic                         eng_mode_o,
    output logic [KEY_SIZE-1:0]          eng_key_o,
    output logic                         eng_key_valid_o,
    input  logic                         eng_key_ready_i,
    output logic [95:0]                  eng_iv_o,
    output logic                         eng_iv_valid_o,
    output logic [127:0]                 eng_din_o,
    output logic                         eng_din_valid_o,
    input  logic                         eng_din_ready_i,
    output logic                         eng_din_last_o,
    input  logic [127:0]                 eng_dout_i,
    input  logic                         eng_dout_valid_i,
    input  logic [127:0]                 eng_tag_i,
    input  logic                         eng_tag_valid_i
);
    localparam int unsigned IDX_W = $clog2(NUM_CH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DATA, S_TAG, S_REL} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [NUM_CH-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0]   sess_cnt_q, sess_cnt_d;
    logic [127:0]       tag_q, tag_d;
    logic [NUM_CH-1:0]  tag_valid_q, tag_valid_d;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
`ifndef GCM_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
`endif

    // First requester found scanning from the start point; only the first hit is taken.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand      = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
`ifdef GCM_ARB_FIXED_PRIO_EN
            cand = IDX_W'(i);
`else
            cand = IDX_W'((32'(rr_ptr_q) + 32'd1 + i) % NUM_CH);
`endif
            if (!sel_found && req_i[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        gnt_idx_d       = gnt_idx_q;
        grant_d         = grant_q;
        sess_cnt_d      = sess_cnt_q;
        tag_d           = tag_q;
        tag_valid_d     = '0;
`ifndef GCM_ARB_FIXED_PRIO_EN
        rr_ptr_d        = rr_ptr_q;
`endif
        eng_mode_o      = 1'b0;
        eng_key_o       = '0;
        eng_key_valid_o = 1'b0;
        eng_iv_o        = '0;
        eng_iv_valid_o  = 1'b0;
        eng_din_o       = '0;
        eng_din_valid_o = 1'b0;
        eng_din_last_o  = 1'b0;
        din_ready_o     = '0;
        dout_valid_o    = '0;

        if (state_q != S_IDLE) eng_mode_o = mode_i[gnt_idx_q];

        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    gnt_idx_d = sel_idx;
                    grant_d   = NUM_CH'(1) << sel_idx;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                eng_key_o       = key_i[32'(gnt_idx_q) * KEY_SIZE +: KEY_SIZE];
                eng_key_valid_o = 1'b1;
                eng_iv_o        = iv_i[32'(gnt_idx_q) * 96 +: 96];
                eng_iv_valid_o  = 1'b1;
                if (eng_key_ready_i) state_d = S_DATA;
            end
            S_DATA: begin
                eng_din_o       = din_i[32'(gnt_idx_q) * 128 +: 128];
                eng_din_valid_o = din_valid_i[gnt_idx_q];
                eng_din_last_o  = din_last_i[gnt_idx_q];
                din_ready_o     = grant_q & {NUM_CH{eng_din_ready_i}};
                dout_valid_o    = grant_q & {NUM_CH{eng_dout_valid_i}};
                if (din_valid_i[gnt_idx_q] && eng_din_ready_i && din_last_i[gnt_idx_q])
                    state_d = S_TAG;
            end
            S_TAG: begin
                dout_valid_o = grant_q & {NUM_CH{eng_dout_valid_i}};
                if (eng_tag_valid_i) begin
                    tag_d       = eng_tag_i;
                    tag_valid_d = grant_q;
                    state_d     = S_REL;
                end
            end
            S_REL: begin
`ifndef GCM_ARB_FIXED_PRIO_EN
                rr_ptr_d   = gnt_idx_q;
`endif
                sess_cnt_d = sess_cnt_q + 1'b1;
                grant_d    = '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gnt_idx_q   <= '0;
            grant_q     <= '0;
            sess_cnt_q  <= '0;
            tag_q       <= '0;
            tag_valid_q <= '0;
`ifndef GCM_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= IDX_W'(NUM_CH - 1);
`endif
        end else begin
            state_q     <= state_d;
            gnt_idx_q   <= gnt_idx_d;
            grant_q     <= grant_d;
            sess_cnt_q  <= sess_cnt_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
`ifndef GCM_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign dout_o      = eng_dout_i;
    assign tag_o       = tag_q;
    assign tag_valid_o = tag_valid_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q != S_IDLE);
    assign sess_cnt_o  = sess_cnt_q;

endmodule

// File: tb/tb_aes_gcm_arbiter.sv
// Directed bench for aes_gcm_arbiter with a simple engine stand-in (dout = din ^ key, tag = key ^ {nblk, iv}).
module tb_aes_gcm_arbiter;
    localparam int unsigned NCH = 4;
    localparam logic [127:0] KEY_BASE = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [95:0]  IV_BASE  = 96'hcafebabefacedbaddecaf888;

    logic               clk;
    logic               rst;
    logic [NCH-1:0]     req_i, mode_i, din_valid_i, din_last_i;
    logic [NCH*128-1:0] key_i, din_i;
    logic [NCH*96-1:0]  iv_i;
    logic [NCH-1:0]     din_ready_o, dout_valid_o, tag_valid_o, grant_o;
    logic [127:0]       dout_o, tag_o;
    logic               busy_o;
    logic [15:0]        sess_cnt_o;
    logic               eng_mode_o, eng_key_valid_o, eng_key_ready_i, eng_iv_valid_o;
    logic [127:0]       eng_key_o, eng_din_o, eng_dout_i, eng_tag_i;
    logic [95:0]        eng_iv_o;
    logic               eng_din_valid_o, eng_din_ready_i, eng_din_last_o;
    logic               eng_dout_valid_i, eng_tag_valid_i;

    aes_gcm_arbiter #(.NUM_CH(NCH), .KEY_SIZE(128), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .mode_i(mode_i), .key_i(key_i), .iv_i(iv_i),
        .din_i(din_i), .din_valid_i(din_valid_i), .din_last_i(din_last_i), .din_ready_o(din_ready_o),
        .dout_o(dout_o), .dout_valid_o(dout_valid_o), .tag_o(tag_o), .tag_valid_o(tag_valid_o),
        .grant_o(grant_o), .busy_o(busy_o), .sess_cnt_o(sess_cnt_o),
        .eng_mode_o(eng_mode_o), .eng_key_o(eng_key_o), .eng_key_valid_o(eng_key_valid_o),
        .eng_key_ready_i(eng_key_ready_i), .eng_iv_o(eng_iv_o), .eng_iv_valid_o(eng_iv_valid_o),
        .eng_din_o(eng_din_o), .eng_din_valid_o(eng_din_valid_o), .eng_din_ready_i(eng_din_ready_i),
        .eng_din_last_o(eng_din_last_o), .eng_dout_i(eng_dout_i), .eng_dout_valid_i(eng_dout_valid_i),
        .eng_tag_i(eng_tag_i), .eng_tag_valid_i(eng_tag_valid_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine stand-in: key accepted after one wait cycle, dout one cycle after each beat, tag 3 cycles after last.
    logic [127:0] m_key;
    logic [95:0]  m_iv;
    logic [31:0]  m_nb;
    logic [1:0]   m_tcnt;
    logic         m_tog;
    logic         bp_en;
    assign eng_din_ready_i = bp_en ? m_tog : 1'b1;

    always @(posedge clk) begin
        if (rst) begin
            eng_key_ready_i <= 1'b0; eng_dout_valid_i <= 1'b0; eng_dout_i <= '0;
            eng_tag_valid_i <= 1'b0; eng_tag_i <= '0;
            m_key <= '0; m_iv <= '0; m_nb <= '0; m_tcnt <= '0; m_tog <= 1'b1;
        end else begin
            m_tog           <= ~m_tog;
            eng_key_ready_i <= eng_key_valid_o && !eng_key_ready_i;
            if (eng_key_valid_o && eng_key_ready_i) begin
                m_key <= eng_key_o; m_iv <= eng_iv_o; m_nb <= '0;
            end
            eng_dout_valid_i <= eng_din_valid_o && eng_din_ready_i;
            eng_dout_i       <= eng_din_o ^ m_key;
            if (eng_din_valid_o && eng_din_ready_i) m_nb <= m_nb + 1;
            if (eng_din_valid_o && eng_din_ready_i && eng_din_last_o) m_tcnt <= 2'd2;
            else if (m_tcnt != 0) m_tcnt <= m_tcnt - 1'b1;
            eng_tag_valid_i <= (m_tcnt == 2'd1);
            eng_tag_i       <= m_key ^ {m_nb, m_iv};
        end
    end

    typedef struct { int ch; logic [127:0] data; } ev_t;

    int unsigned  sess_left [NCH];
    int unsigned  nblk      [NCH];
    int unsigned  sent      [NCH];
    logic         noise     [NCH];
    logic [127:0] keys      [NCH];
    logic [95:0]  ivs       [NCH];
    ev_t          dout_log[$];
    ev_t          tag_log[$];
    int           gnt_log[$];
    logic [NCH-1:0] prev_grant;
    int unsigned  stray_rdy, stray_dv, stray_vld, mirror_err, bp_stalls;
    int unsigned  vectors, miscompares;

    function automatic logic [127:0] blk(input int c, input int unsigned k);
        return {32'hD0D0_0000 | 32'(c), 32'(k), 64'h0123_4567_89ab_cdef};
    endfunction

    task automatic apply();
        for (int c = 0; c < NCH; c++) begin
            req_i[c]       = (sess_left[c] != 0);
            din_valid_i[c] = noise[c] || (sess_left[c] != 0 && sent[c] < nblk[c]);
            din_last_i[c]  = (sent[c] + 1 == nblk[c]);
            din_i[c*128 +: 128] = blk(c, sent[c]);
            key_i[c*128 +: 128] = keys[c];
            iv_i[c*96 +: 96]    = ivs[c];
            mode_i[c]      = 1'b0;
        end
    endtask

    task automatic clear_logs();
        dout_log.delete(); tag_log.delete(); gnt_log.delete();
        stray_rdy = 0; stray_dv = 0; stray_vld = 0; mirror_err = 0; bp_stalls = 0;
    endtask

    // One clock: observe on the falling edge, then advance the channel front-ends after the rising edge.
    task automatic step();
        logic [NCH-1:0] fire;
        @(negedge clk);
        fire = din_valid_i & din_ready_o;
        if (|(din_ready_o & ~grant_o)) stray_rdy++;
        if (|(dout_valid_o & ~grant_o)) stray_dv++;
        if (eng_din_valid_o && !(|(din_valid_i & grant_o))) stray_vld++;
        if (|din_ready_o && !eng_din_ready_i) mirror_err++;
        if (eng_din_valid_o && eng_din_ready_i && !(|(din_ready_o & grant_o))) mirror_err++;
        if (eng_din_valid_o && !eng_din_ready_i) bp_stalls++;
        for (int c = 0; c < NCH; c++)
            if (dout_valid_o[c]) dout_log.push_back('{ch: c, data: dout_o});
        if (grant_o != '0 && grant_o != prev_grant)
            for (int c = 0; c < NCH; c++) if (grant_o[c]) gnt_log.push_back(c);
        prev_grant = grant_o;
        @(posedge clk); #1;
        for (int c = 0; c < NCH; c++) if (fire[c]) sent[c]++;
        for (int c = 0; c < NCH; c++)
            if (tag_valid_o[c]) begin
                tag_log.push_back('{ch: c, data: tag_o});
                sent[c] = 0;
                if (sess_left[c] != 0) sess_left[c]--;
            end
        apply();
    endtask

    task automatic run(input int unsigned budget, output bit done);
        done = 1'b0;
        for (int unsigned n = 0; n < budget && !done; n++) begin
            step();
            done = !busy_o;
            for (int c = 0; c < NCH; c++) if (sess_left[c] != 0) done = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int c = 0; c < NCH; c++) begin sess_left[c] = 0; sent[c] = 0; noise[c] = 1'b0; end
        apply();
        @(posedge clk); #1;
        rst = 1'b0;
        prev_grant = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (grant_o !== 4'b0000) begin $display("FAIL reset_grant: got %b, expected 0000", grant_o); miscompares++; end
        vectors++; if (busy_o !== 1'b0) begin $display("FAIL reset_busy: got %b, expected 0", busy_o); miscompares++; end
        vectors++; if (sess_cnt_o !== 16'd0) begin $display("FAIL reset_sess_cnt: got %0d, expected 0", sess_cnt_o); miscompares++; end
        vectors++; if (tag_valid_o !== 4'b0000) begin $display("FAIL reset_tag_valid: got %b, expected 0000", tag_valid_o); miscompares++; end
        vectors++; if (tag_o !== 128'd0) begin $display("FAIL reset_tag: got %h, expected 0", tag_o); miscompares++; end
        vectors++; if (din_ready_o !== 4'b0000) begin $display("FAIL reset_din_ready: got %b, expected 0000", din_ready_o); miscompares++; end
        vectors++; if ({eng_key_valid_o, eng_iv_valid_o, eng_din_valid_o, eng_mode_o} !== 4'b0000) begin
            $display("FAIL reset_eng_ctrl: got %b, expected 0000", {eng_key_valid_o, eng_iv_valid_o, eng_din_valid_o, eng_mode_o}); miscompares++;
        end
        rst = 1'b0;
        prev_grant = '0;
    endtask

    task automatic test_single_session();
        bit done;
        clear_logs();
        sess_left[1] = 1; nblk[1] = 4;
        apply();
        step();
        vectors++; if (grant_o !== 4'b0010) begin $display("FAIL single_grant: got %b, expected 0010", grant_o); miscompares++; end
        vectors++; if (busy_o !== 1'b1) begin $display("FAIL single_busy: got %b, expected 1", busy_o); miscompares++; end
        vectors++; if (eng_key_valid_o !== 1'b1 || eng_key_o !== KEY_BASE) begin
            $display("FAIL single_key: got valid=%b key=%h, expected valid=1 key=%h", eng_key_valid_o, eng_key_o, KEY_BASE); miscompares++;
        end
        vectors++; if (eng_iv_valid_o !== 1'b1 || eng_iv_o !== IV_BASE) begin
            $display("FAIL single_iv: got valid=%b iv=%h, expected valid=1 iv=%h", eng_iv_valid_o, eng_iv_o, IV_BASE); miscompares++;
        end
        run(100, done);
        vectors++; if (!done) begin $display("FAIL single_timeout: session not finished within 100 cycles, expected completion"); miscompares++; end
        vectors++; if (dout_log.size() != 4) begin $display("FAIL single_dout_count: got %0d, expected 4", dout_log.size()); miscompares++; end
        for (int i = 0; i < dout_log.size(); i++) begin
            vectors++;
            if (dout_log[i].ch != 1 || dout_log[i].data !== (blk(1, i) ^ KEY_BASE)) begin
                $display("FAIL single_dout%0d: got ch%0d %h, expected ch1 %h", i, dout_log[i].ch, dout_log[i].data, blk(1, i) ^ KEY_BASE); miscompares++;
            end
        end
        vectors++; if (tag_log.size() != 1) begin $display("FAIL single_tag_count: got %0d, expected 1", tag_log.size()); miscompares++; end
        else begin
            vectors++;
            if (tag_log[0].ch != 1 || tag_log[0].data !== (KEY_BASE ^ {32'd4, IV_BASE})) begin
                $display("FAIL single_tag: got ch%0d %h, expected ch1 %h", tag_log[0].ch, tag_log[0].data, KEY_BASE ^ {32'd4, IV_BASE}); miscompares++;
            end
        end
        vectors++; if (sess_cnt_o !== 16'd1) begin $display("FAIL single_sess_cnt: got %0d, expected 1", sess_cnt_o); miscompares++; end
        vectors++; if (grant_o !== 4'b0000) begin $display("FAIL single_released: got %b, expected 0000", grant_o); miscompares++; end
        vectors++; if (stray_rdy + stray_dv != 0) begin $display("FAIL single_stray: got %0d stray cycles, expected 0", stray_rdy + stray_dv); miscompares++; end
    endtask

    task automatic test_fairness();
        bit done;
        int exp_order [5];
        int seen [NCH];
`ifdef GCM_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 1, 2, 3};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        do_reset();
        clear_logs();
        sess_left[0] = 2; sess_left[1] = 1; sess_left[2] = 1; sess_left[3] = 1;
        for (int c = 0; c < NCH; c++) begin nblk[c] = 2; seen[c] = 0; end
        apply();
        run(400, done);
        vectors++; if (!done) begin $display("FAIL fair_timeout: sessions not finished within 400 cycles, expected completion"); miscompares++; end
        vectors++; if (gnt_log.size() != 5) begin $display("FAIL fair_grant_count: got %0d, expected 5", gnt_log.size()); miscompares++; end
        for (int i = 0; i < gnt_log.size() && i < 5; i++) begin
            vectors++;
            if (gnt_log[i] != exp_order[i]) begin $display("FAIL fair_order%0d: got ch%0d, expected ch%0d", i, gnt_log[i], exp_order[i]); miscompares++; end
        end
        vectors++; if (tag_log.size() != 5) begin $display("FAIL fair_tag_count: got %0d, expected 5", tag_log.size()); miscompares++; end
        for (int i = 0; i < tag_log.size() && i < 5; i++) begin
            vectors++;
            if (tag_log[i].ch != exp_order[i] || tag_log[i].data !== (keys[exp_order[i]] ^ {32'd2, ivs[exp_order[i]]})) begin
                $display("FAIL fair_tag%0d: got ch%0d %h, expected ch%0d %h", i, tag_log[i].ch, tag_log[i].data,
                         exp_order[i], keys[exp_order[i]] ^ {32'd2, ivs[exp_order[i]]}); miscompares++;
            end
        end
        vectors++; if (dout_log.size() != 10) begin $display("FAIL fair_dout_count: got %0d, expected 10", dout_log.size()); miscompares++; end
        for (int i = 0; i < dout_log.size(); i++) begin
            int c;
            c = dout_log[i].ch;
            vectors++;
            if (dout_log[i].data !== (blk(c, seen[c] % 2) ^ keys[c])) begin
                $display("FAIL fair_dout%0d: got ch%0d %h, expected %h", i, c, dout_log[i].data, blk(c, seen[c] % 2) ^ keys[c]); miscompares++;
            end
            seen[c]++;
        end
        vectors++; if (sess_cnt_o !== 16'd5) begin $display("FAIL fair_sess_cnt: got %0d, expected 5", sess_cnt_o); miscompares++; end
        vectors++; if (stray_rdy + stray_dv + stray_vld != 0) begin $display("FAIL fair_stray: got %0d stray cycles, expected 0", stray_rdy + stray_dv + stray_vld); miscompares++; end
    endtask

    task automatic test_backpressure();
        bit done;
        clear_logs();
        bp_en = 1'b1;
        sess_left[2] = 1; nblk[2] = 4;
        apply();
        run(200, done);
        bp_en = 1'b0;
        vectors++; if (!done) begin $display("FAIL bp_timeout: session not finished within 200 cycles, expected completion"); miscompares++; end
        vectors++; if (gnt_log.size() != 1 || gnt_log[0] != 2) begin $display("FAIL bp_grant: got %0d grants, expected one grant to ch2", gnt_log.size()); miscompares++; end
        vectors++; if (dout_log.size() != 4) begin $display("FAIL bp_dout_count: got %0d, expected 4", dout_log.size()); miscompares++; end
        for (int i = 0; i < dout_log.size(); i++) begin
            vectors++;
            if (dout_log[i].ch != 2 || dout_log[i].data !== (blk(2, i) ^ keys[2])) begin
                $display("FAIL bp_dout%0d: got ch%0d %h, expected ch2 %h", i, dout_log[i].ch, dout_log[i].data, blk(2, i) ^ keys[2]); miscompares++;
            end
        end
        vectors++; if (mirror_err != 0) begin $display("FAIL bp_ready_mirror: got %0d bad cycles, expected 0", mirror_err); miscompares++; end
        vectors++; if (stray_rdy != 0) begin $display("FAIL bp_other_ready: got %0d cycles, expected 0", stray_rdy); miscompares++; end
        vectors++; if (bp_stalls == 0) begin $display("FAIL bp_stalls: got 0 stalled beats, expected at least 1"); miscompares++; end
    endtask

    task automatic test_noise();
        bit done;
        int ch3_dv;
        clear_logs();
        noise[3] = 1'b1;
        sess_left[0] = 1; nblk[0] = 3;
        apply();
        step();
        vectors++; if (grant_o !== 4'b0001) begin $display("FAIL noise_grant: got %b, expected 0001", grant_o); miscompares++; end
        run(100, done);
        noise[3] = 1'b0;
        apply();
        vectors++; if (!done) begin $display("FAIL noise_timeout: session not finished within 100 cycles, expected completion"); miscompares++; end
        vectors++; if (stray_vld != 0) begin $display("FAIL noise_eng_valid: got %0d foreign-valid cycles, expected 0", stray_vld); miscompares++; end
        ch3_dv = 0;
        foreach (dout_log[i]) if (dout_log[i].ch == 3) ch3_dv++;
        vectors++; if (ch3_dv != 0) begin $display("FAIL noise_dout_valid3: got %0d pulses, expected 0", ch3_dv); miscompares++; end
        vectors++; if (dout_log.size() != 3) begin $display("FAIL noise_dout_count: got %0d, expected 3", dout_log.size()); miscompares++; end
        for (int i = 0; i < dout_log.size(); i++) begin
            vectors++;
            if (dout_log[i].data !== (blk(0, i) ^ keys[0])) begin
                $display("FAIL noise_dout%0d: got %h, expected %h", i, dout_log[i].data, blk(0, i) ^ keys[0]); miscompares++;
            end
        end
    endtask

    task automatic test_reset_mid();
        bit done, hit;
        clear_logs();
        sess_left[2] = 1; nblk[2] = 6;
        apply();
        hit = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
            step();
            hit = eng_din_valid_o && grant_o[2];
        end
        vectors++; if (!hit) begin $display("FAIL rstmid_reach_data: ch2 data phase not reached in 20 cycles, expected reached"); miscompares++; end
        rst = 1'b1;
        step();
        vectors++; if (grant_o !== 4'b0000) begin $display("FAIL rstmid_grant: got %b, expected 0000", grant_o); miscompares++; end
        vectors++; if (busy_o !== 1'b0) begin $display("FAIL rstmid_busy: got %b, expected 0", busy_o); miscompares++; end
        vectors++; if (sess_cnt_o !== 16'd0) begin $display("FAIL rstmid_sess_cnt: got %0d, expected 0", sess_cnt_o); miscompares++; end
        rst = 1'b0;
        prev_grant = '0;
        clear_logs();
        for (int c = 0; c < NCH; c++) begin sess_left[c] = 1; nblk[c] = 1; sent[c] = 0; end
        apply();
        step();
        vectors++; if (grant_o !== 4'b0001) begin $display("FAIL rstmid_first_grant: got %b, expected 0001", grant_o); miscompares++; end
        run(300, done);
        vectors++; if (!done) begin $display("FAIL rstmid_timeout: sessions not finished within 300 cycles, expected completion"); miscompares++; end
        vectors++; if (sess_cnt_o !== 16'd4) begin $display("FAIL rstmid_sess_cnt_after: got %0d, expected 4", sess_cnt_o); miscompares++; end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        bp_en = 1'b0; rst = 1'b1; prev_grant = '0;
        for (int c = 0; c < NCH; c++) begin
            keys[c] = KEY_BASE ^ (128'(c ^ 1) << 120);
            ivs[c]  = IV_BASE ^ (96'(c ^ 1) << 88);
            sess_left[c] = 0; nblk[c] = 1; sent[c] = 0; noise[c] = 1'b0;
        end
        clear_logs();
        test_reset();
        test_single_session();
        test_fairness();
        test_backpressure();
        test_noise();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units, expected to finish earlier");
        $fatal(1, "watchdog");
    end

endmodule
